// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the single slave.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface bus_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_we;
    logic          m0_re;
    logic [DW-1:0] m0_rdata;
    logic          m0_done;

    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_we;
    logic          m1_re;
    logic [DW-1:0] m1_rdata;
    logic          m1_done;

    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_we;
    logic          s_re;
    logic [DW-1:0] s_rdata;

    logic          busy;
    logic          owner;

    modport master (
        input  m0_addr, m0_wdata, m0_we, m0_re,
        input  m1_addr, m1_wdata, m1_we, m1_re,
        input  s_rdata,
        output m0_rdata, m0_done, m1_rdata, m1_done,
        output s_addr, s_wdata, s_we, s_re,
        output busy, owner
    );

    modport slave (
        output m0_addr, m0_wdata, m0_we, m0_re,
        output m1_addr, m1_wdata, m1_we, m1_re,
        output s_rdata,
        input  m0_rdata, m0_done, m1_rdata, m1_done,
        input  s_addr, s_wdata, s_we, s_re,
        input  busy, owner
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one registered slave port; one transaction
// at a time, IDLE -> ISSUE -> (WAIT x RD_LAT) -> RESP, all outputs registered.
module bus_arbiter #(
    parameter int AW     = 64,
    parameter int DW     = 64,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    bus_arbiter_if.master   bus
);
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_owner;
    logic          w_owner_next;
    logic          r_last_owner;
    logic          w_last_next;
    logic          r_is_write;
    logic          w_is_write_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    logic [AW-1:0] r_s_addr;
    logic [AW-1:0] w_s_addr_next;
    logic [DW-1:0] r_s_wdata;
    logic [DW-1:0] w_s_wdata_next;
    logic          r_s_we;
    logic          w_s_we_next;
    logic          r_s_re;
    logic          w_s_re_next;
    logic [1:0]    r_done;
    logic [1:0]    w_done_next;
    logic          r_busy;
    logic          w_busy_next;
    logic          w_win;

    logic [1:0]          w_we;
    logic [1:0]          w_req;
    logic [1:0][AW-1:0]  w_addr;
    logic [1:0][DW-1:0]  w_wdata;

    assign w_we    = {bus.m1_we, bus.m0_we};
    assign w_req   = {bus.m1_we | bus.m1_re, bus.m0_we | bus.m0_re};
    assign w_addr  = {bus.m1_addr, bus.m0_addr};
    assign w_wdata = {bus.m1_wdata, bus.m0_wdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_is_write   <= 1'b0;
            r_cnt        <= '0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
            r_s_we       <= 1'b0;
            r_s_re       <= 1'b0;
            r_done       <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_next;
            r_is_write   <= w_is_write_next;
            r_cnt        <= w_cnt_next;
            r_s_addr     <= w_s_addr_next;
            r_s_wdata    <= w_s_wdata_next;
            r_s_we       <= w_s_we_next;
            r_s_re       <= w_s_re_next;
            r_done       <= w_done_next;
            r_busy       <= w_busy_next;
        end
    end

    // Slave strobes and done pulses are computed one state ahead so they appear
    // from registers in exactly the ISSUE / RESP cycle.
    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_last_next     = r_last_owner;
        w_is_write_next = r_is_write;
        w_cnt_next      = r_cnt;
        w_s_addr_next   = '0;
        w_s_wdata_next  = '0;
        w_s_we_next     = 1'b0;
        w_s_re_next     = 1'b0;
        w_done_next     = '0;
        w_win           = 1'b0;

        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    if (&w_req) w_win = ~r_last_owner;
                    else        w_win = w_req[1];
                    w_state_next    = ISSUE;
                    w_owner_next    = w_win;
                    w_last_next     = w_win;
                    w_is_write_next = w_we[w_win];
                    w_s_addr_next   = w_addr[w_win];
                    w_s_we_next     = w_we[w_win];
                    w_s_re_next     = ~w_we[w_win];
                    w_s_wdata_next  = w_we[w_win] ? w_wdata[w_win] : '0;
                end
            end
            ISSUE: begin
                if (r_is_write) begin
                    w_state_next         = RESP;
                    w_done_next[r_owner] = 1'b1;
                end else begin
                    w_state_next = WAIT;
                    w_cnt_next   = CW'(RD_LAT);
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_next         = RESP;
                    w_done_next[r_owner] = 1'b1;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        w_busy_next = (w_state_next != IDLE);
    end

    // Read data is captured only for the owner, on the edge that ends the last WAIT cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        logic          w_capture;
        logic [DW-1:0] r_rdata;

        assign w_capture = w_done_next[gi] && (r_state == WAIT);

        always_ff @(posedge clk or posedge reset) begin
            if (reset)          r_rdata <= '0;
            else if (w_capture) r_rdata <= bus.s_rdata;
        end
    end

    assign bus.m0_rdata = g_master[0].r_rdata;
    assign bus.m1_rdata = g_master[1].r_rdata;
    assign bus.m0_done  = r_done[0];
    assign bus.m1_done  = r_done[1];
    assign bus.s_addr   = r_s_addr;
    assign bus.s_wdata  = r_s_wdata;
    assign bus.s_we     = r_s_we;
    assign bus.s_re     = r_s_re;
    assign bus.busy     = r_busy;
    assign bus.owner    = r_owner;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: one instance at RD_LAT=1, one at RD_LAT=4,
// each with a slave model that drives junk except in the cycle the data is due.
module tb_bus_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_arbiter_if #(.AW(AW), .DW(DW)) bif1 ();
    bus_arbiter_if #(.AW(AW), .DW(DW)) bif4 ();

    bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (.clk(clk), .reset(rst), .bus(bif1));
    bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(4)) dut4 (.clk(clk), .reset(rst), .bus(bif4));

    typedef struct {
        int          d;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          cyc;
    } slv_t;

    typedef struct {
        int          d;
        int          who;
        bit          rd;
        logic [63:0] data;
        int          cyc;
    } rsp_t;

    slv_t        q_slv[$];
    rsp_t        q_rsp[$];
    logic [63:0] exp_rd [2][2];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rd_fn(input logic [63:0] a);
        if (a == 64'h2000_0000) return 64'hDEAD_BEEF;
        return a ^ 64'h5A5A_0F0F_C3C3_9669;
    endfunction

    // Slave models: data is valid only in the cycle RD_LAT after the s_re cycle.
    int          cnt1 = 0, cnt4 = 0;
    logic [63:0] sa1, sa4;
    always @(negedge clk) begin
        logic [63:0] nxt1, nxt4;
        nxt1 = {$urandom, $urandom};
        nxt4 = {$urandom, $urandom};
        if (rst) begin
            cnt1 = 0;
            cnt4 = 0;
        end else begin
            if (cnt1 > 0) begin cnt1--; if (cnt1 == 0) nxt1 = rd_fn(sa1); end
            if (bif1.s_re) begin cnt1 = 1; sa1 = bif1.s_addr; end
            if (cnt4 > 0) begin cnt4--; if (cnt4 == 0) nxt4 = rd_fn(sa4); end
            if (bif4.s_re) begin cnt4 = 4; sa4 = bif4.s_addr; end
        end
        bif1.s_rdata = nxt1;
        bif4.s_rdata = nxt4;
    end

    task automatic monitor(input int d, input logic swe, input logic sre,
                           input logic [63:0] saddr, input logic [63:0] swdata,
                           input logic d0, input logic d1,
                           input logic [63:0] rd0, input logic [63:0] rd1,
                           input logic own, input logic bsy);
        slv_t s;
        rsp_t r;
        if (swe || sre) begin
            check("s_excl", swe & sre, 0);
            if (q_slv.size() == 0) check("s_unexpected", q_slv.size(), 1);
            else begin
                s = q_slv.pop_front();
                check("s_dut", d, s.d);
                check("s_we", swe, s.we);
                check("s_re", sre, !s.we);
                check("s_addr", saddr, s.addr);
                if (s.we) check("s_wdata", swdata, s.wdata);
                check("s_cycle", cyc, s.cyc);
            end
        end
        if (d0 || d1) begin
            check("done_excl", d0 & d1, 0);
            if (q_rsp.size() == 0) check("done_unexpected", q_rsp.size(), 1);
            else begin
                r = q_rsp.pop_front();
                check("done_dut", d, r.d);
                check("done_who", d1, r.who);
                check("owner", own, r.who);
                check("busy_resp", bsy, 1);
                check("done_cycle", cyc, r.cyc);
                if (r.rd) exp_rd[d][r.who] = r.data;
                check("m0_rdata", rd0, exp_rd[d][0]);
                check("m1_rdata", rd1, exp_rd[d][1]);
                $display("[%0d] dut%0d m%0d done %s rdata0=%h rdata1=%h", cyc, d, r.who,
                         r.rd ? "read " : "write", rd0, rd1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            monitor(0, bif1.s_we, bif1.s_re, bif1.s_addr, bif1.s_wdata, bif1.m0_done,
                    bif1.m1_done, bif1.m0_rdata, bif1.m1_rdata, bif1.owner, bif1.busy);
            monitor(1, bif4.s_we, bif4.s_re, bif4.s_addr, bif4.s_wdata, bif4.m0_done,
                    bif4.m1_done, bif4.m0_rdata, bif4.m1_rdata, bif4.owner, bif4.busy);
        end
    end

    task automatic set_req(input int d, input int m, input bit we, input bit re,
                           input logic [63:0] addr, input logic [63:0] wdata);
        if (d == 0 && m == 0) begin
            bif1.m0_we = we; bif1.m0_re = re; bif1.m0_addr = addr; bif1.m0_wdata = wdata;
        end else if (d == 0) begin
            bif1.m1_we = we; bif1.m1_re = re; bif1.m1_addr = addr; bif1.m1_wdata = wdata;
        end else if (m == 0) begin
            bif4.m0_we = we; bif4.m0_re = re; bif4.m0_addr = addr; bif4.m0_wdata = wdata;
        end else begin
            bif4.m1_we = we; bif4.m1_re = re; bif4.m1_addr = addr; bif4.m1_wdata = wdata;
        end
    endtask

    task automatic push_exp(input int d, input int m, input bit we, input logic [63:0] addr,
                            input logic [63:0] wdata, input int t_issue, input int t_done);
        slv_t s;
        rsp_t r;
        s.d = d; s.we = we; s.addr = addr; s.wdata = wdata; s.cyc = t_issue;
        q_slv.push_back(s);
        r.d = d; r.who = m; r.rd = !we; r.data = we ? 64'd0 : rd_fn(addr); r.cyc = t_done;
        q_rsp.push_back(r);
    endtask

    // Called in the IDLE cycle t0; write done at t0+2, read done at t0+2+lat.
    task automatic drive(input int d, input int m, input bit we, input bit re,
                         input logic [63:0] addr, input logic [63:0] wdata, input int lat);
        set_req(d, m, we, re, addr, wdata);
        push_exp(d, m, we, addr, wdata, cyc + 1, we ? cyc + 2 : cyc + 2 + lat);
    endtask

    function automatic bit get_done(input int d, input int m);
        if (d == 0) return (m == 0) ? bif1.m0_done : bif1.m1_done;
        return (m == 0) ? bif4.m0_done : bif4.m1_done;
    endfunction

    task automatic wait_done(input int d, input int m);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = get_done(d, m);
        end
        check("done_seen", seen, 1);
        set_req(d, m, 0, 0, 64'd0, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          n1;
        bit          we;
        logic [63:0] a;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                set_req(d, m, 0, 0, 64'd0, 64'd0);
                exp_rd[d][m] = 64'd0;
            end
        end

        repeat (2) @(negedge clk);
        check("rst_busy", bif1.busy, 0);
        check("rst_owner", bif1.owner, 0);
        check("rst_s_we", bif1.s_we, 0);
        check("rst_s_re", bif1.s_re, 0);
        check("rst_s_addr", bif1.s_addr, 0);
        check("rst_m0_done", bif1.m0_done, 0);
        check("rst_m1_rdata", bif1.m1_rdata, 0);
        rst = 1'b0;

        @(negedge clk); drive(0, 0, 1, 0, 64'h1000_0000, 64'h41, 1);         wait_done(0, 0);
        @(negedge clk); drive(0, 1, 0, 1, 64'h2000_0000, 64'd0, 1);          wait_done(0, 1);
        @(negedge clk); drive(0, 0, 1, 1, 64'h1000_0008, 64'h1234_5678, 1);  wait_done(0, 0);

        for (int i = 0; i < 6; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom} & ~64'h7;
            @(negedge clk); drive(0, i % 2, we, !we, a, {$urandom, $urandom}, 1);
            wait_done(0, i % 2);
        end

        @(negedge clk); drive(1, 0, 0, 1, 64'h3000_0040, 64'd0, 4); wait_done(1, 0);
        @(negedge clk); drive(1, 1, 0, 1, 64'h3000_0080, 64'd0, 4); wait_done(1, 1);
        @(negedge clk); drive(1, 0, 1, 0, 64'h3000_00C0, 64'h77, 4); wait_done(1, 0);

        // Reset in the middle of a read: the in-flight done must never appear.
        @(negedge clk); drive(0, 0, 0, 1, 64'h4000_0000, 64'd0, 1);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", bif1.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", bif1.busy, 0);
        check("arst_s_re", bif1.s_re, 0);
        check("arst_m0_done", bif1.m0_done, 0);
        check("arst_m0_rdata", bif1.m0_rdata, 0);
        check("arst_m1_rdata", bif1.m1_rdata, 0);
        check("arst_dut4_m1_rdata", bif4.m1_rdata, 0);
        q_rsp.delete();
        for (int d = 0; d < 2; d++) for (int m = 0; m < 2; m++) exp_rd[d][m] = 64'd0;

        // Both masters held from reset release: m0 first, then strict alternation.
        set_req(0, 1, 1, 0, 64'h5000_0010, 64'hCAFE);
        @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        push_exp(0, 0, 0, 64'h4000_0000, 64'd0,   t0 + 1,  t0 + 3);
        push_exp(0, 1, 1, 64'h5000_0010, 64'hCAFE, t0 + 5,  t0 + 6);
        push_exp(0, 0, 0, 64'h4000_0000, 64'd0,   t0 + 8,  t0 + 10);
        push_exp(0, 1, 1, 64'h5000_0010, 64'hCAFE, t0 + 12, t0 + 13);
        n1 = 0;
        for (int i = 0; i < 60 && n1 < 2; i++) begin
            @(negedge clk);
            if (bif1.m1_done) n1++;
        end
        check("contention_m1_dones", n1, 2);
        set_req(0, 0, 0, 0, 64'd0, 64'd0);
        set_req(0, 1, 0, 0, 64'd0, 64'd0);

        repeat (4) @(negedge clk);
        check("slv_q_empty", q_slv.size(), 0);
        check("rsp_q_empty", q_rsp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
